leading_run_sequencer: RTL and testbench
========================================

// Module: leading_run_sequencer
// PURPOSE
//  Multi-cycle leading-run counter for the decode path (posit regime field).
//  Accepts one WIDTH-bit word over valid/ready. Scans it MSB-first, one 4-bit slice
//  per cycle, through a single shared priority_encoder_4. Returns the run length of
//  bits equal to the MSB. Trades latency for area versus a flat WIDTH-wide encoder.
// PARAMETERS
//  WIDTH   32                   input word width; multiple of 4, >= 8 (elab $error otherwise)
//  CNT_W   $clog2(WIDTH+1)      out_count width (derived, do not override)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  in_valid     in   1      in_data valid
//  in_ready     out  1      block can accept a word
//  in_data      in   WIDTH  word to scan
//  out_valid    out  1      result valid
//  out_ready    in   1      consumer accepts result
//  out_count    out  CNT_W  run length including MSB, range 1..WIDTH
//  out_leading  out  1      value of the run bit (in_data[WIDTH-1])
//  out_all_same out  1      run covers the entire word (out_count == WIDTH)
// BEHAVIOUR
//  - Reset: state=IDLE, out_valid=0, out_count=0, out_leading=0, out_all_same=0.
//    in_ready=0 while rst is high.
//  - FSM IDLE -> SCAN -> DONE.
//    IDLE: in_ready=1. On in_valid&in_ready: latch word, leading=word[MSB], acc=0,
//    idx=0, go to SCAN.
//  - SCAN: feed slice idx (bits WIDTH-1-4*idx downto WIDTH-4-4*idx) and the latched
//    leading bit to the encoder.
//    If enc.valid: out_count=acc+enc.count, out_all_same=0, go to DONE.
//    Else if idx is the last slice: out_count=WIDTH, out_all_same=1, go to DONE.
//    Else: acc+=4, idx++.
//  - Slice 0 always contains the MSB, so the slice-0 count is >= 1 and out_count is
//    never 0 in DONE.
//  - Latency: terminator in slice i -> out_valid rises i+1 edges after the accepting
//    edge. Worst case WIDTH/4.
//  - DONE: out_valid=1. out_count, out_leading and out_all_same are held stable until
//    out_valid&out_ready. Then go to IDLE.
//  - acc is CNT_W wide; no overflow, since the maximum is WIDTH.
//  - in_data is ignored outside the accepting cycle. Input changes during SCAN have no
//    effect.
//  - rst at any state, including mid-SCAN and DONE with out_ready=0: abandon the word,
//    apply reset values on the next edge. No partial result is emitted.
// CONFIGURATION
//  LEADING_RUN_BACK_TO_BACK_EN
//   defined: in_ready = (IDLE) | (DONE & out_ready). If a result is consumed and a new
//     word is accepted on the same edge, go DONE -> SCAN directly. No bubble.
//   undefined: in_ready only in IDLE. At least one idle cycle between words.
// STRUCTURE
//  - leading_run_pkg holds:
//    - typedef enum logic [1:0] {LRS_IDLE, LRS_SCAN, LRS_DONE} lrs_state_t
//    - localparam SLICE_W = 4
//    - function lrs_cnt_w(width) returning $clog2(width+1)
//  - One sub-module: the existing priority_encoder_4, instantiated once (leading_bit,
//    slice -> count, valid).
//  - Slice select uses an indexed part-select on the latched word. No shift register.
// TESTING (WIDTH=32)
//  1. 32'h8000_0000 -> out_count=1, out_leading=1, out_all_same=0; out_valid 1 edge
//     after accept.
//  2. 32'h0000_1000 -> out_count=19, out_leading=0; terminator in slice 4, out_valid
//     5 edges after accept.
//  3. 32'hFFFF_FFFF -> 32, leading=1, all_same=1.
//     32'h0000_0000 -> 32, leading=0, all_same=1. Each takes 8 edges.
//  4. Hold out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0 (macro off),
//     result consumed on the 4th cycle.
//  5. rst pulse mid-SCAN of 32'h0000_0001 -> out_valid stays 0, state IDLE. The next
//     word 32'hF000_0000 yields count=4 exactly.
//  6. Two words with in_valid held and out_ready=1 -> macro on: 2nd accepted on the 1st
//     result's handshake edge. Macro off: one cycle with in_ready=1 and no transfer
//     between them.
//  Bench: scoreboard vs. a reference-model clz/clo count on random words; assert
//  out_count in 1..WIDTH whenever out_valid.

Source files
------------

// File: rtl/leading_run_pkg.sv
// Shared types and constants for the leading-run sequencer.
//   lrs_state_t : sequencer FSM states
//   SLICE_W     : bits examined per scan cycle
//   lrs_cnt_w() : width needed to hold a run length of 0..width
package leading_run_pkg;

    typedef enum logic [1:0] {
        LRS_IDLE,
        LRS_SCAN,
        LRS_DONE
    } lrs_state_t;

    localparam int unsigned SLICE_W = 4;

    function automatic int unsigned lrs_cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/priority_encoder_4.sv
// 4-bit leading-run priority encoder.
//   leading_bit_i : run bit value being matched
//   slice_i       : 4-bit slice, bit 3 examined first
//   count_o       : bits equal to leading_bit_i before the first differing bit (4 if none)
//   valid_o       : a differing bit (run terminator) exists in this slice
module priority_encoder_4 (
    input  logic       leading_bit_i,
    input  logic [3:0] slice_i,
    output logic [2:0] count_o,
    output logic       valid_o
);

    logic [3:0] diff;

    assign diff    = slice_i ^ {4{leading_bit_i}};
    assign valid_o = |diff;

    always_comb begin
        count_o = 3'd4;
        if (diff[3]) begin
            count_o = 3'd0;
        end else if (diff[2]) begin
            count_o = 3'd1;
        end else if (diff[1]) begin
            count_o = 3'd2;
        end else if (diff[0]) begin
            count_o = 3'd3;
        end
    end

endmodule

// File: rtl/leading_run_sequencer.sv
// Multi-cycle leading-run counter: accepts one WIDTH-bit word, scans it MSB-first one
// 4-bit slice per cycle through a single shared encoder, and returns the length of the
// run of bits equal to the MSB.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   in_valid_i/in_ready_o/in_data_i        : input word handshake
//   out_valid_o/out_ready_i                : result handshake
//   out_count_o    : run length including the MSB (1..WIDTH)
//   out_leading_o  : value of the run bit
//   out_all_same_o : run covers the whole word
// Optional feature macro LEADING_RUN_BACK_TO_BACK_EN: when defined, a new word may be
// accepted on the same edge that the previous result is consumed (DONE -> SCAN).
module leading_run_sequencer
    import leading_run_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = lrs_cnt_w(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [CNT_W-1:0] out_count_o,
    output logic             out_leading_o,
    output logic             out_all_same_o
);

    localparam int unsigned NSLICE = WIDTH / SLICE_W;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int unsigned BASE_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    if (((WIDTH % SLICE_W) != 0) || (WIDTH < 8)) begin : g_width_check
        $error("leading_run_sequencer: WIDTH must be a multiple of 4 and >= 8");
    end

    lrs_state_t       state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             leading_q, leading_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             all_same_q, all_same_d;

    logic              in_ready;
    logic              accept;
    logic [BASE_W-1:0] slice_base;
    logic [3:0]        slice;
    logic [2:0]        enc_count;
    logic              enc_valid;

    // Slice idx occupies bits WIDTH-1-4*idx downto WIDTH-4-4*idx.
    assign slice_base = BASE_W'(WIDTH - SLICE_W) - BASE_W'(idx_q) * BASE_W'(SLICE_W);
    assign slice      = word_q[slice_base +: SLICE_W];

    priority_encoder_4 u_enc (
        .leading_bit_i (leading_q),
        .slice_i       (slice),
        .count_o       (enc_count),
        .valid_o       (enc_valid)
    );

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            LRS_IDLE: in_ready = 1'b1;
`ifdef LEADING_RUN_BACK_TO_BACK_EN
            LRS_DONE: in_ready = out_ready_i;
`endif
            default:  in_ready = 1'b0;
        endcase
        if (rst_i) begin
            in_ready = 1'b0;
        end
    end

    assign accept = in_valid_i & in_ready;

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        leading_d  = leading_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        count_d    = count_q;
        all_same_d = all_same_q;

        case (state_q)
            LRS_SCAN: begin
                if (enc_valid) begin
                    count_d    = acc_q + CNT_W'(enc_count);
                    all_same_d = 1'b0;
                    state_d    = LRS_DONE;
                end else if (idx_q == LAST_IDX) begin
                    count_d    = CNT_W'(WIDTH);
                    all_same_d = 1'b1;
                    state_d    = LRS_DONE;
                end else begin
                    acc_d = acc_q + CNT_W'(SLICE_W);
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            LRS_DONE: begin
                if (out_ready_i) begin
                    state_d = LRS_IDLE;
                end
            end
            default: ;
        endcase

        // Accept can only happen in IDLE or on the DONE handshake; it overrides both.
        if (accept) begin
            word_d    = in_data_i;
            leading_d = in_data_i[WIDTH-1];
            acc_d     = '0;
            idx_d     = '0;
            state_d   = LRS_SCAN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= LRS_IDLE;
            word_q     <= '0;
            leading_q  <= 1'b0;
            acc_q      <= '0;
            idx_q      <= '0;
            count_q    <= '0;
            all_same_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            leading_q  <= leading_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            all_same_q <= all_same_d;
        end
    end

    assign in_ready_o     = in_ready;
    assign out_valid_o    = (state_q == LRS_DONE);
    assign out_count_o    = count_q;
    assign out_leading_o  = leading_q;
    assign out_all_same_o = all_same_q;

endmodule

// File: tb/tb_leading_run_sequencer.sv
`timescale 1ns/1ps
module tb_leading_run_sequencer;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic             out_leading;
    logic             out_all_same;

    always #5 clk = ~clk;

    leading_run_sequencer #(.WIDTH(WIDTH)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_data_i      (in_data),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_count_o    (out_count),
        .out_leading_o  (out_leading),
        .out_all_same_o (out_all_same)
    );

    int n_pass = 0;
    int n_total = 0;
    int range_err = 0;

    typedef struct {
        logic [31:0] data;
        int          count;
        int          leading;
        int          all_same;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Any valid result must have a count in 1..WIDTH.
    always @(negedge clk) begin
        if (!rst && out_valid && ((out_count == 0) || (out_count > WIDTH))) range_err++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        ok = in_ready;
    endtask

    task automatic wait_valid(output int lat, output bit ok);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        ok = out_valid;
    endtask

    // Send one word, consume its result; lat = edges from accept to out_valid.
    task automatic run_word(input logic [31:0] data, output int cnt, output int lead,
                            output int same, output int lat, output bit ok);
        bit rdy_ok;
        bit val_ok;
        cnt = 0; lead = 0; same = 0; lat = 0;
        in_data  = data;
        in_valid = 1'b1;
        wait_ready(rdy_ok);
        tick();
        in_valid = 1'b0;
        in_data  = ~data;  // must be ignored during SCAN
        wait_valid(lat, val_ok);
        ok = rdy_ok && val_ok;
        if (ok) begin
            cnt  = int'(out_count);
            lead = int'(out_leading);
            same = int'(out_all_same);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    function automatic int ref_run(input logic [31:0] w);
        int c = 1;
        while (c < 32 && w[31-c] == w[31]) c++;
        return c;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int  cnt, lead, same, lat, n, pulses;
        bit  ok;
        logic [31:0] w;

        vecs[0] = '{32'h8000_0000,  1, 1, 0, 1};
        vecs[1] = '{32'h0000_1000, 19, 0, 0, 5};
        vecs[2] = '{32'hFFFF_FFFF, 32, 1, 1, 8};
        vecs[3] = '{32'h0000_0000, 32, 0, 1, 8};
        vecs[4] = '{32'hF000_0000,  4, 1, 0, 2};
        vecs[5] = '{32'h7FFF_FFFF,  1, 0, 0, 1};
        vecs[6] = '{32'hFFFF_FFFE, 31, 1, 0, 8};
        vecs[7] = '{32'h0000_000F, 28, 0, 0, 8};
        vecs[8] = '{32'h3000_0000,  2, 0, 0, 1};
        vecs[9] = '{32'h0FFF_FFFF,  4, 0, 0, 2};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick(); tick();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_count", int'(out_count), 0);
        check("rst_out_leading", int'(out_leading), 0);
        check("rst_out_all_same", int'(out_all_same), 0);
        check("rst_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", int'(in_ready), 1);

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            run_word(vecs[i].data, cnt, lead, same, lat, ok);
            check($sformatf("vec%0d_handshake", i), int'(ok), 1);
            check($sformatf("vec%0d_count", i), cnt, vecs[i].count);
            check($sformatf("vec%0d_leading", i), lead, vecs[i].leading);
            check($sformatf("vec%0d_all_same", i), same, vecs[i].all_same);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        // Result held with out_ready low for 3 cycles, consumed on the 4th.
        in_data = 32'h00F0_0000; in_valid = 1'b1;
        wait_ready(ok);
        tick();
        in_valid = 1'b0;
        wait_valid(lat, ok);
        check("hold_handshake", int'(ok), 1);
        check("hold_latency", lat, 3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("hold%0d_valid", k), int'(out_valid), 1);
            check($sformatf("hold%0d_count", k), int'(out_count), 8);
            check($sformatf("hold%0d_leading", k), int'(out_leading), 0);
            check($sformatf("hold%0d_in_ready", k), int'(in_ready), 0);
            tick();
        end
        check("hold3_valid", int'(out_valid), 1);
        check("hold3_count", int'(out_count), 8);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hold_consumed_valid", int'(out_valid), 0);
        check("hold_consumed_idle", int'(in_ready), 1);

        // Reset mid-SCAN abandons the word.
        in_data = 32'h0000_0001; in_valid = 1'b1;
        wait_ready(ok);
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        check("midscan_no_valid", int'(out_valid), 0);
        rst = 1'b1;
        #1;
        check("midscan_rst_in_ready", int'(in_ready), 0);
        tick();
        rst = 1'b0;
        #1;
        check("midscan_after_rst_valid", int'(out_valid), 0);
        check("midscan_after_rst_idle", int'(in_ready), 1);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            if (out_valid) pulses++;
            tick();
        end
        check("midscan_no_partial", pulses, 0);
        run_word(32'hF000_0000, cnt, lead, same, lat, ok);
        check("after_rst_handshake", int'(ok), 1);
        check("after_rst_count", cnt, 4);
        check("after_rst_leading", lead, 1);

        // Two words back-to-back with in_valid held and out_ready high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h8000_0000;
        wait_ready(ok);
        check("b2b_a_accept", int'(ok), 1);
        tick();
        in_data = 32'h0000_1000;
        wait_valid(lat, ok);
        check("b2b_a_valid", int'(ok), 1);
        check("b2b_a_count", int'(out_count), 1);
`ifdef LEADING_RUN_BACK_TO_BACK_EN
        check("b2b_ready_in_done", int'(in_ready), 1);
        tick();
        check("b2b_scan_valid", int'(out_valid), 0);
        check("b2b_scan_ready", int'(in_ready), 0);
`else
        check("b2b_ready_in_done", int'(in_ready), 0);
        tick();
        check("b2b_bubble_valid", int'(out_valid), 0);
        check("b2b_bubble_ready", int'(in_ready), 1);
        tick();
        check("b2b_scan_ready", int'(in_ready), 0);
`endif
        in_valid = 1'b0;
        wait_valid(lat, ok);
        check("b2b_b_valid", int'(ok), 1);
        check("b2b_b_count", int'(out_count), 19);
        check("b2b_b_leading", int'(out_leading), 0);
        tick();
        out_ready = 1'b0;
        check("b2b_done_idle", int'(in_ready), 1);

        // Random words with a chosen run length, checked against a reference count.
        for (int i = 0; i < 24; i++) begin
            int r;
            logic b;
            int exp_lat;
            r = int'($urandom_range(1, 32));
            b = 1'($urandom_range(0, 1));
            w = $urandom;
            for (int j = 0; j < r; j++) w[31-j] = b;
            if (r < 32) w[31-r] = ~b;
            exp_lat = (r < 32) ? (r / 4 + 1) : 8;
            run_word(w, cnt, lead, same, lat, ok);
            check($sformatf("rand%0d_handshake", i), int'(ok), 1);
            check($sformatf("rand%0d_count", i), cnt, ref_run(w));
            check($sformatf("rand%0d_leading", i), lead, int'(w[31]));
            check($sformatf("rand%0d_all_same", i), same, (ref_run(w) == 32) ? 1 : 0);
            check($sformatf("rand%0d_latency", i), lat, exp_lat);
        end

        check("count_range", range_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
